lorenz_dac_streamer: RTL and testbench

- Downstream consumer of the Lorenz oscillator state outputs (xn, yn, zn; signed Q10.21 in 32 bits).
- Decimates the state stream and converts each channel to a 12-bit offset-binary DAC code with saturation.
- Shifts the codes out as three consecutive 16-bit SPI frames to a 3-channel DAC, so the attractor can be displayed on an oscilloscope (X/Y/Z).

---
 rtl/lorenz_dac_streamer.sv | 241 ++++++++++++++++++++++++
 tb/tb_lorenz_dac_streamer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lorenz_dac_streamer.sv
// Purpose: decimate the Lorenz oscillator state stream and send X/Y/Z as 12-bit offset-binary
//          codes in three consecutive 16-bit SPI frames to a 3-channel DAC for scope display.
// Latency: cs_n_o falls 1 cycle after a capture event. One frame takes 1+35*ClkDiv cycles.
//          A full sample takes 3 frames.
// Backpressure: none toward the oscillator. A decimated sample that arrives while a transfer is
//          in flight is dropped, and the sticky overrun_o flag is set.
//
// Ports:
//   clk_i, rst_i            clock (rising edge) / asynchronous active-high reset
//   start_i                 streaming enable; low holds the decimator at 0 and clears overrun_o
//   valid_i                 one-cycle strobe qualifying xn_i/yn_i/zn_i
//   xn_i, yn_i, zn_i        signed oscillator state, Q(Width-21).21
//   sclk_o, mosi_o, cs_n_o  SPI mode 0 master, MSB first
//   busy_o                  FSM not idle
//   overrun_o               sticky: a decimated sample was dropped
module lorenz_dac_streamer #(
    parameter int Width   = 32,
    parameter int Shift   = 16,
    parameter int DacBits = 12,
    parameter int Decim   = 256,
    parameter int ClkDiv  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             valid_i,
    input  logic [Width-1:0] xn_i,
    input  logic [Width-1:0] yn_i,
    input  logic [Width-1:0] zn_i,
    output logic             sclk_o,
    output logic             mosi_o,
    output logic             cs_n_o,
    output logic             busy_o,
    output logic             overrun_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    localparam int CntW = (Decim > 1) ? $clog2(Decim) : 1;
    localparam int DivW = $clog2(2 * ClkDiv);

    localparam logic [CntW-1:0] CntLast   = CntW'(Decim - 1);
    localparam logic [DivW-1:0] PhaseLast = DivW'(ClkDiv - 1);
    localparam logic [DivW-1:0] GapLast   = DivW'(2 * ClkDiv - 1);

    // Two's complement: ~max == -max-1 == most negative DAC code.
    localparam logic signed [Width-1:0] SatMax = Width'((2 ** (DacBits - 1)) - 1);
    localparam logic signed [Width-1:0] SatMin = ~SatMax;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CntW-1:0]         r_cnt;
    logic signed [Width-1:0] r_x;
    logic signed [Width-1:0] r_y;
    logic signed [Width-1:0] r_z;
    logic [1:0]              r_chan;
    logic [1:0]              w_chan_nxt;
    logic [DivW-1:0]         r_div;
    logic [DivW-1:0]         w_div_nxt;
    logic                    r_phase;
    logic                    w_phase_nxt;
    logic [3:0]              r_bit;
    logic [3:0]              w_bit_nxt;
    logic                    r_overrun;

    logic                    w_capture;
    logic                    w_accept;
    logic signed [Width-1:0] w_sel;
    logic signed [Width-1:0] w_shift;
    logic [DacBits-1:0]      w_code;
    logic [15:0]             w_frame;
    logic                    w_frame_bit;

    // A capture event is the first strobe of each Decim-long window.
    assign w_capture = valid_i & start_i & (r_cnt == '0);
    assign w_accept  = w_capture & (r_state == S_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (!start_i) begin
            r_cnt <= '0;
        end else if (valid_i) begin
            r_cnt <= (r_cnt == CntLast) ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overrun <= 1'b0;
        end else if (!start_i) begin
            r_overrun <= 1'b0;
        end else if (w_capture && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_x <= '0;
            r_y <= '0;
            r_z <= '0;
        end else if (w_accept) begin
            r_x <= xn_i;
            r_y <= yn_i;
            r_z <= zn_i;
        end
    end

    // Convert the channel currently being shifted. The shift and clamp use the full
    // Width, so out-of-range states saturate instead of wrapping.
    always_comb begin
        w_sel = r_z;
        case (r_chan)
            2'd0:    w_sel = r_x;
            2'd1:    w_sel = r_y;
            default: w_sel = r_z;
        endcase
        w_shift = w_sel >>> Shift;
        if (w_shift > SatMax) begin
            w_code = '1;
        end else if (w_shift < SatMin) begin
            w_code = '0;
        end else begin
            // Adding the mid-scale offset equals inverting the sign bit.
            w_code = {~w_shift[DacBits-1], w_shift[DacBits-2:0]};
        end
        w_frame     = {r_chan, {(14 - DacBits){1'b0}}, w_code};
        w_frame_bit = w_frame[4'd15 - r_bit];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_chan  <= '0;
            r_div   <= '0;
            r_phase <= 1'b0;
            r_bit   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_chan  <= w_chan_nxt;
            r_div   <= w_div_nxt;
            r_phase <= w_phase_nxt;
            r_bit   <= w_bit_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_chan_nxt  = r_chan;
        w_div_nxt   = r_div;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit;
        sclk_o      = 1'b0;
        mosi_o      = 1'b0;
        cs_n_o      = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_LOAD;
                    w_chan_nxt  = 2'd0;
                    w_div_nxt   = '0;
                    w_phase_nxt = 1'b0;
                    w_bit_nxt   = '0;
                end
            end

            S_LOAD: begin
                cs_n_o      = 1'b0;
                mosi_o      = w_frame_bit;
                w_state_nxt = S_SHIFT;
                w_div_nxt   = '0;
                w_phase_nxt = 1'b0;
                w_bit_nxt   = '0;
            end

            S_SHIFT: begin
                cs_n_o = 1'b0;
                sclk_o = r_phase;
                mosi_o = w_frame_bit;
                if (r_div == PhaseLast) begin
                    w_div_nxt   = '0;
                    w_phase_nxt = ~r_phase;
                    // The bit index advances together with the sclk fall, so mosi
                    // only changes while sclk is low.
                    if (r_phase) begin
                        if (r_bit == 4'd15) begin
                            w_state_nxt = S_HOLD;
                        end else begin
                            w_bit_nxt = r_bit + 4'd1;
                        end
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end

            S_HOLD: begin
                cs_n_o = 1'b0;
                mosi_o = w_frame_bit;
                if (r_div == PhaseLast) begin
                    w_div_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end

            S_GAP: begin
                if (r_div == GapLast) begin
                    w_div_nxt = '0;
                    if (r_chan != 2'd2) begin
                        w_chan_nxt  = r_chan + 2'd1;
                        w_phase_nxt = 1'b0;
                        w_bit_nxt   = '0;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy_o    = (r_state != S_IDLE);
    assign overrun_o = r_overrun;

endmodule

// File: tb/tb_lorenz_dac_streamer.sv
// Directed bench for lorenz_dac_streamer: one instance with Decim=1 and one with Decim=4.
// SPI frames are reassembled from the pins and then compared with hand-computed codes.
module tb_lorenz_dac_streamer;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        start1 = 1'b0;
    logic        start4 = 1'b0;
    logic        valid  = 1'b0;
    logic [31:0] xn     = '0;
    logic [31:0] yn     = '0;
    logic [31:0] zn     = '0;

    logic sclk1, mosi1, cs1, busy1, ovr1;
    logic sclk4, mosi4, cs4, busy4, ovr4;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lorenz_dac_streamer #(.Decim(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .valid_i(valid),
        .xn_i(xn), .yn_i(yn), .zn_i(zn),
        .sclk_o(sclk1), .mosi_o(mosi1), .cs_n_o(cs1), .busy_o(busy1), .overrun_o(ovr1)
    );

    lorenz_dac_streamer #(.Decim(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .valid_i(valid),
        .xn_i(xn), .yn_i(yn), .zn_i(zn),
        .sclk_o(sclk4), .mosi_o(mosi4), .cs_n_o(cs4), .busy_o(busy4), .overrun_o(ovr4)
    );

    // SPI receivers: shift on sclk rise inside the cs window, store frame on cs rise.
    logic [15:0] sh1, sh4;
    int          rises1, rises4;
    logic [15:0] fq1[$];
    logic [15:0] fq4[$];
    int          rq1[$];
    int          rq4[$];
    int          viol1 = 0;
    int          viol4 = 0;

    always @(negedge cs1) begin sh1 = '0; rises1 = 0; end
    always @(posedge sclk1) if (cs1 === 1'b0) begin sh1 = {sh1[14:0], mosi1}; rises1++; end
    always @(posedge cs1) if (!rst) begin fq1.push_back(sh1); rq1.push_back(rises1); end

    always @(negedge cs4) begin sh4 = '0; rises4 = 0; end
    always @(posedge sclk4) if (cs4 === 1'b0) begin sh4 = {sh4[14:0], mosi4}; rises4++; end
    always @(posedge cs4) if (!rst) begin fq4.push_back(sh4); rq4.push_back(rises4); end

    always @(negedge clk) begin
        if (sclk1 === 1'b1 && cs1 === 1'b1) viol1++;
        if (sclk4 === 1'b1 && cs4 === 1'b1) viol4++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_idle1(output int n);
        n = 0;
        while (busy1 === 1'b1 && n < 2000) begin tick(); n++; end
    endtask

    task automatic wait_idle4(output int n);
        n = 0;
        while (busy4 === 1'b1 && n < 2000) begin tick(); n++; end
    endtask

    task automatic test_reset();
        #2;
        n_assert++;
        if ({cs1, sclk1, mosi1, busy1, ovr1} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_dut1 {cs,sclk,mosi,busy,ovr} got %b want 10000", {cs1, sclk1, mosi1, busy1, ovr1});
        end
        n_assert++;
        if ({cs4, sclk4, mosi4, busy4, ovr4} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_dut4 {cs,sclk,mosi,busy,ovr} got %b want 10000", {cs4, sclk4, mosi4, busy4, ovr4});
        end
        rst = 1'b0;
        tickn(3);
        n_assert++;
        if (busy1 !== 1'b0 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle busy1=%b busy4=%b want 0", busy1, busy4);
        end
    endtask

    task automatic test_basic();
        int n;
        logic [15:0] exp [3];
        exp = '{16'h0800, 16'h4820, 16'h87E0};
        fq1.delete(); rq1.delete();
        xn = 32'h0000_0000; yn = 32'h0020_0000; zn = 32'hFFE0_0000;
        start1 = 1'b1;
        tick();
        n_assert++;
        if (cs1 !== 1'b1) begin n_fail++; $display("FAIL basic_cs_before got %b want 1", cs1); end
        valid = 1'b1;
        tick();
        valid = 1'b0;
        n_assert++;
        if (cs1 !== 1'b0 || sclk1 !== 1'b0 || mosi1 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_load_cycle cs=%b sclk=%b mosi=%b want 0/0/0", cs1, sclk1, mosi1);
        end
        wait_idle1(n);
        n_assert++;
        if (n != 423) begin n_fail++; $display("FAIL basic_sample_cycles got %0d want 423", n); end
        n_assert++;
        if (fq1.size() != 3) begin
            n_fail++; $display("FAIL basic_frame_count got %0d want 3", fq1.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_assert++;
                if (fq1[i] !== exp[i] || rq1[i] != 16) begin
                    n_fail++;
                    $display("FAIL basic_frame%0d got %h/%0d rises want %h/16", i, fq1[i], rq1[i], exp[i]);
                end
            end
        end
        start1 = 1'b0;
        tick();
    endtask

    task automatic test_saturation();
        int n;
        logic [15:0] exp [3];
        exp = '{16'h0FFF, 16'h4000, 16'h8FFF};
        fq1.delete(); rq1.delete();
        xn = 32'h0C80_0000; yn = 32'hF380_0000; zn = 32'h7FFF_FFFF;
        start1 = 1'b1;
        tick();
        valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_idle1(n);
        n_assert++;
        if (fq1.size() != 3) begin
            n_fail++; $display("FAIL sat_frame_count got %0d want 3", fq1.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_assert++;
                if (fq1[i] !== exp[i] || rq1[i] != 16) begin
                    n_fail++;
                    $display("FAIL sat_frame%0d got %h/%0d rises want %h/16", i, fq1[i], rq1[i], exp[i]);
                end
            end
        end
        start1 = 1'b0;
        tick();
    endtask

    task automatic test_decim();
        int left, first_drop, acc, seen_ovr, bmis, fmis, n;
        logic [15:0] exp [3];
        exp = '{16'h0800, 16'h4820, 16'h87E0};
        left = 0; first_drop = -1; acc = 0; seen_ovr = -1; bmis = 0; fmis = 0;
        fq4.delete(); rq4.delete();
        xn = 32'h0000_0000; yn = 32'h0020_0000; zn = 32'hFFE0_0000;
        start4 = 1'b1;
        tick();
        valid = 1'b1;
        for (int k = 1; k <= 2000; k++) begin
            tick();
            // Pulse k is a capture event when (k-1)%4==0. An event is accepted only when
            // the previous 423-cycle sample has fully finished.
            if (((k - 1) % 4) == 0 && left == 0) begin
                acc++;
                left = 423;
            end else begin
                if (((k - 1) % 4) == 0 && first_drop < 0) first_drop = k;
                if (left > 0) left--;
            end
            if (busy4 !== (left > 0)) bmis++;
            if (ovr4 === 1'b1 && seen_ovr < 0) seen_ovr = k;
        end
        valid = 1'b0;
        n_assert++;
        if (bmis != 0) begin n_fail++; $display("FAIL decim_busy_timeline got %0d mismatching cycles want 0", bmis); end
        n_assert++;
        if (seen_ovr != first_drop) begin
            n_fail++; $display("FAIL decim_overrun_rise got pulse %0d want pulse %0d", seen_ovr, first_drop);
        end
        wait_idle4(n);
        n_assert++;
        if (busy4 !== 1'b0) begin n_fail++; $display("FAIL decim_drain busy got %b want 0", busy4); end
        n_assert++;
        if (fq4.size() != 3 * acc) begin
            n_fail++; $display("FAIL decim_frame_count got %0d want %0d", fq4.size(), 3 * acc);
        end else begin
            for (int i = 0; i < fq4.size(); i++)
                if (fq4[i] !== exp[i % 3] || rq4[i] != 16) fmis++;
            n_assert++;
            if (fmis != 0) begin n_fail++; $display("FAIL decim_frame_content got %0d bad frames want 0", fmis); end
        end
        n_assert++;
        if (ovr4 !== 1'b1) begin n_fail++; $display("FAIL decim_overrun_sticky got %b want 1", ovr4); end
        start4 = 1'b0;
        tick();
        n_assert++;
        if (ovr4 !== 1'b0) begin n_fail++; $display("FAIL decim_overrun_clear got %b want 0", ovr4); end
    endtask

    task automatic test_gap_pulse();
        int n;
        fq1.delete(); rq1.delete();
        xn = 32'h0000_0000; yn = 32'h0020_0000; zn = 32'hFFE0_0000;
        start1 = 1'b1;
        tick();
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tickn(422);
        n_assert++;
        if (busy1 !== 1'b1 || cs1 !== 1'b1) begin
            n_fail++; $display("FAIL gap_last_cycle busy=%b cs=%b want 1/1", busy1, cs1);
        end
        valid = 1'b1;
        tick();
        n_assert++;
        if (busy1 !== 1'b0 || ovr1 !== 1'b1) begin
            n_fail++; $display("FAIL gap_pulse_dropped busy=%b ovr=%b want 0/1", busy1, ovr1);
        end
        tick();
        valid = 1'b0;
        n_assert++;
        if (busy1 !== 1'b1 || cs1 !== 1'b0) begin
            n_fail++; $display("FAIL idle_pulse_accepted busy=%b cs=%b want 1/0", busy1, cs1);
        end
        wait_idle1(n);
        n_assert++;
        if (n != 423 || fq1.size() != 6) begin
            n_fail++; $display("FAIL gap_second_sample got %0d cycles/%0d frames want 423/6", n, fq1.size());
        end
        n_assert++;
        if (ovr1 !== 1'b1) begin n_fail++; $display("FAIL gap_overrun_sticky got %b want 1", ovr1); end
        start1 = 1'b0;
        tick();
        n_assert++;
        if (ovr1 !== 1'b0) begin n_fail++; $display("FAIL gap_overrun_clear got %b want 0", ovr1); end
    endtask

    task automatic test_start_drop();
        int n, bcnt;
        logic [15:0] exp [3];
        exp = '{16'h0FFF, 16'h4000, 16'h8FFF};
        fq1.delete(); rq1.delete();
        xn = 32'h0C80_0000; yn = 32'hF380_0000; zn = 32'h7FFF_FFFF;
        start1 = 1'b1;
        tick();
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tickn(160);
        n_assert++;
        if (cs1 !== 1'b0 || fq1.size() != 1) begin
            n_fail++; $display("FAIL stop_in_y_frame cs=%b frames=%0d want 0/1", cs1, fq1.size());
        end
        start1 = 1'b0;
        wait_idle1(n);
        n_assert++;
        if (n != 263) begin n_fail++; $display("FAIL stop_remaining_cycles got %0d want 263", n); end
        n_assert++;
        if (fq1.size() != 3) begin
            n_fail++; $display("FAIL stop_frame_count got %0d want 3", fq1.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_assert++;
                if (fq1[i] !== exp[i] || rq1[i] != 16) begin
                    n_fail++;
                    $display("FAIL stop_frame%0d got %h/%0d rises want %h/16", i, fq1[i], rq1[i], exp[i]);
                end
            end
        end
        bcnt = 0;
        valid = 1'b1;
        for (int i = 0; i < 20; i++) begin tick(); if (busy1 !== 1'b0) bcnt++; end
        valid = 1'b0;
        n_assert++;
        if (bcnt != 0 || fq1.size() != 3) begin
            n_fail++; $display("FAIL stop_ignores_valid busy_cycles=%0d frames=%0d want 0/3", bcnt, fq1.size());
        end
    endtask

    task automatic test_reset_mid();
        int n, bcnt;
        start1 = 1'b1;
        tick();
        valid = 1'b1;
        tick();
        valid = 1'b0;
        tickn(50);
        n_assert++;
        if (cs1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_shift cs got %b want 0", cs1); end
        #3 rst = 1'b1;
        #1;
        n_assert++;
        if ({cs1, sclk1, mosi1, busy1} !== 4'b1000) begin
            n_fail++; $display("FAIL rstmid_async {cs,sclk,mosi,busy} got %b want 1000", {cs1, sclk1, mosi1, busy1});
        end
        #2 rst = 1'b0;
        fq1.delete(); rq1.delete();
        bcnt = 0;
        for (int i = 0; i < 200; i++) begin tick(); if (busy1 !== 1'b0) bcnt++; end
        n_assert++;
        if (bcnt != 0 || fq1.size() != 0) begin
            n_fail++; $display("FAIL rstmid_quiet busy_cycles=%0d frames=%0d want 0/0", bcnt, fq1.size());
        end
        valid = 1'b1;
        tick();
        valid = 1'b0;
        n_assert++;
        if (busy1 !== 1'b1) begin n_fail++; $display("FAIL rstmid_recapture busy got %b want 1", busy1); end
        wait_idle1(n);
        n_assert++;
        if (n != 423 || fq1.size() != 3) begin
            n_fail++; $display("FAIL rstmid_sample got %0d cycles/%0d frames want 423/3", n, fq1.size());
        end
        start1 = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_decim();
        test_gap_pulse();
        test_start_drop();
        test_reset_mid();
        n_assert++;
        if (viol1 != 0 || viol4 != 0) begin
            n_fail++; $display("FAIL sclk_high_outside_cs got %0d/%0d cycles want 0/0", viol1, viol4);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
